// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: freeze/flush sequencing for PC, IF/ID and ID/EXE with stall/flush statistics and memory-timeout flag
module pipe_hazard_ctrl #(
  parameter bit FWD_EN      = 1'b1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       exe_dest,
  input  logic             mem_wb_en,
  input  logic [3:0]       mem_dest,
  input  logic             exe_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             freeze_pc,
  output logic             freeze_ifid,
  output logic             flush_ifid,
  output logic             flush_idexe,
  output logic             stall_all,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout_err
);
  typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, BR_SHADOW = 2'b10, ILLEGAL = 2'b11} state_e;
  localparam logic [11:0] TMO = 12'(MEM_TIMEOUT);
  state_e state_q, state_d;
  logic [11:0] wait_q, wait_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic err_q, err_d;
  logic hit1, hit2, hazard, mwait, stall, br, bubble;
  assign hit1 = FWD_EN ? (exe_wb_en & exe_mem_r_en & (exe_dest == id_src1))
                       : ((exe_wb_en & (exe_dest == id_src1)) | (mem_wb_en & (mem_dest == id_src1)));
  assign hit2 = FWD_EN ? (exe_wb_en & exe_mem_r_en & (exe_dest == id_src2))
                       : ((exe_wb_en & (exe_dest == id_src2)) | (mem_wb_en & (mem_dest == id_src2)));
  assign hazard = id_valid & ((id_use_src1 & hit1) | (id_use_src2 & hit2));
  assign mwait  = mem_req & ~mem_ready;
  // EXE holds a bubble in BR_SHADOW, and MEM_WAIT ignores branch/hazard until it exits
  always_comb begin
    stall       = mwait & (state_q != ILLEGAL);
    br          = ~mwait & exe_branch_taken & (state_q == RUN);
    bubble      = ~mwait & ~br & hazard & ((state_q == RUN) | (state_q == BR_SHADOW));
    state_d     = stall ? MEM_WAIT : br ? BR_SHADOW : RUN;
    stall_cnt_d = ((stall | bubble) && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    flush_cnt_d = (br && flush_cnt_q != '1) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    wait_d      = !stall ? 12'd0 : (wait_q == TMO) ? wait_q : wait_q + 12'd1;
    err_d       = err_q | (wait_d == TMO);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      wait_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      err_q       <= err_d;
    end
  end
  assign stall_all       = rst & stall;
  assign freeze_pc       = rst & (stall | bubble);
  assign freeze_ifid     = rst & (stall | bubble);
  assign flush_ifid      = rst & br;
  assign flush_idexe     = rst & (br | bubble);
  assign state           = state_q;
  assign stall_cnt       = stall_cnt_q;
  assign flush_cnt       = flush_cnt_q;
  assign mem_timeout_err = err_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed + random checks of two controllers (with and without forwarding) against a cycle model
module tb_pipe_hazard_ctrl;
  localparam int TMO = 8;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;
  logic clk = 1'b0, rst = 1'b0;
  logic id_valid, id_use_src1, id_use_src2, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic exe_branch_taken, mem_req, mem_ready;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
  logic fpc1, fif1, fli1, fle1, sa1, err1, fpc0, fif0, fli0, fle0, sa0, err0;
  logic [1:0] st1, st0;
  logic [CW-1:0] sc1, fc1, sc0, fc0;
  int passed = 0, total = 0;
  int m_mode, m_sc[2], m_fc[2], m_wt[2];
  bit m_err[2];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FWD_EN(1'b1), .MEM_TIMEOUT(TMO), .CNT_W(CW)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .exe_wb_en(exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en), .exe_dest(exe_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
    .exe_branch_taken(exe_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_pc(fpc1), .freeze_ifid(fif1), .flush_ifid(fli1), .flush_idexe(fle1), .stall_all(sa1),
    .state(st1), .stall_cnt(sc1), .flush_cnt(fc1), .mem_timeout_err(err1));

  pipe_hazard_ctrl #(.FWD_EN(1'b0), .MEM_TIMEOUT(TMO), .CNT_W(CW)) u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .exe_wb_en(exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en), .exe_dest(exe_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
    .exe_branch_taken(exe_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .freeze_pc(fpc0), .freeze_ifid(fif0), .flush_ifid(fli0), .flush_idexe(fle0), .stall_all(sa0),
    .state(st0), .stall_cnt(sc0), .flush_cnt(fc0), .mem_timeout_err(err0));

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic bit hit(int f, logic [3:0] s);
    if (f == 1) return exe_wb_en && exe_mem_r_en && exe_dest == s;
    return (exe_wb_en && exe_dest == s) || (mem_wb_en && mem_dest == s);
  endfunction

  task automatic model_reset();
    m_mode = 0;
    for (int f = 0; f < 2; f++) begin
      m_sc[f] = 0; m_fc[f] = 0; m_wt[f] = 0; m_err[f] = 0;
    end
  endtask

  task automatic idle();
    id_valid = 0; id_use_src1 = 0; id_use_src2 = 0; exe_wb_en = 0; exe_mem_r_en = 0;
    mem_wb_en = 0; exe_branch_taken = 0; mem_req = 0; mem_ready = 0;
    id_src1 = 0; id_src2 = 0; exe_dest = 0; mem_dest = 0;
  endtask

  // mode: 0 running, 1 waiting on memory, 2 one cycle after a taken branch
  task automatic cycle();
    bit stall, br, bub, haz, mw;
    int nmode;
    bit [4:0] ctl;
    #1;
    mw = mem_req && !mem_ready;
    stall = mw;
    br = !mw && m_mode == 0 && exe_branch_taken;
    nmode = mw ? 1 : br ? 2 : 0;
    for (int f = 0; f < 2; f++) begin
      haz = id_valid && ((id_use_src1 && hit(f, id_src1)) || (id_use_src2 && hit(f, id_src2)));
      bub = m_mode != 1 && !mw && !br && haz;
      ctl = {stall, stall || bub, stall || bub, br, br || bub};
      check($sformatf("ctl_fwd%0d", f), f ? {fpc1 & 1'b0, sa1, fpc1, fif1, fli1, fle1} : {1'b0, sa0, fpc0, fif0, fli0, fle0}, 16'(ctl));
      check($sformatf("state_fwd%0d", f), f ? 16'(st1) : 16'(st0), 16'(m_mode));
      check($sformatf("stall_cnt_fwd%0d", f), f ? 16'(sc1) : 16'(sc0), 16'(m_sc[f]));
      check($sformatf("flush_cnt_fwd%0d", f), f ? 16'(fc1) : 16'(fc0), 16'(m_fc[f]));
      check($sformatf("timeout_fwd%0d", f), f ? 16'(err1) : 16'(err0), 16'(m_err[f]));
      if ((stall || bub) && m_sc[f] < SAT) m_sc[f]++;
      if (br && m_fc[f] < SAT) m_fc[f]++;
      m_wt[f] = stall ? (m_wt[f] < TMO ? m_wt[f] + 1 : TMO) : 0;
      if (m_wt[f] == TMO) m_err[f] = 1;
    end
    @(posedge clk);
    m_mode = nmode;
    #1;
  endtask

  task automatic do_reset();
    rst = 0;
    #1;
    check("rst_ctl1", {11'd0, sa1, fpc1, fif1, fli1, fle1}, 16'd0);
    check("rst_ctl0", {11'd0, sa0, fpc0, fif0, fli0, fle0}, 16'd0);
    check("rst_state", {st1, st0}, 16'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1;
  endtask

  initial begin
    idle();
    model_reset();
    @(posedge clk);
    #1;
    check("rst_cnt", {sc1, fc1, sc0, fc0}, 16'd0);
    check("rst_err", {15'd0, err1 | err0}, 16'd0);
    rst = 1;
    cycle();
    // load-use: bubble for one cycle, then load has moved to MEM
    id_valid = 1; id_src1 = 3; id_use_src1 = 1; exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 3;
    cycle();
    check("loaduse_stall_cnt", 16'(sc1), 16'd1);
    exe_wb_en = 0; exe_mem_r_en = 0; mem_wb_en = 1; mem_dest = 3;
    cycle();
    // ALU dependency: only the non-forwarding controller stalls
    idle();
    do_reset();
    id_valid = 1; id_src2 = 5; id_use_src2 = 1; exe_wb_en = 1; exe_dest = 5;
    cycle();
    check("alu_dep_stall", {sc1, sc0}, 16'h01);
    // branch held two cycles: one flush only
    idle();
    do_reset();
    exe_branch_taken = 1;
    cycle();
    cycle();
    idle();
    cycle();
    check("branch_flush_cnt", 16'(fc1), 16'd1);
    // memory wait 4 cycles then ready
    do_reset();
    mem_req = 1;
    repeat (4) cycle();
    mem_ready = 1;
    cycle();
    check("memwait_stall_cnt", 16'(sc1), 16'd4);
    check("memwait_state", 16'(st1), 16'd0);
    // timeout after 8 stalled edges, sticky until reset
    idle();
    do_reset();
    mem_req = 1;
    repeat (7) cycle();
    check("timeout_before", 16'(err1), 16'd0);
    repeat (3) cycle();
    check("timeout_set", 16'(err1), 16'd1);
    mem_ready = 1;
    cycle();
    idle();
    cycle();
    check("timeout_sticky", 16'(err1), 16'd1);
    do_reset();
    check("timeout_cleared", 16'(err1), 16'd0);
    // mwait + branch + load-use: stall only, branch flushes after the ready cycle
    mem_req = 1; exe_branch_taken = 1;
    id_valid = 1; id_src1 = 2; id_use_src1 = 1; exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 2;
    repeat (2) cycle();
    mem_ready = 1;
    cycle();
    mem_req = 0;
    cycle();
    check("simul_flush_cnt", 16'(fc1), 16'd1);
    // async reset in the middle of a memory wait
    idle();
    mem_req = 1;
    cycle();
    cycle();
    rst = 0;
    #1;
    check("async_rst_stall", {14'd0, sa1, sa0}, 16'd0);
    check("async_rst_state", {st1, st0}, 16'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1;
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      id_valid = 1'($urandom_range(0, 3) != 0);
      id_use_src1 = 1'($urandom); id_use_src2 = 1'($urandom);
      id_src1 = 4'($urandom_range(0, 5)); id_src2 = 4'($urandom_range(0, 5));
      exe_wb_en = 1'($urandom); exe_mem_r_en = 1'($urandom); exe_dest = 4'($urandom_range(0, 5));
      mem_wb_en = 1'($urandom); mem_dest = 4'($urandom_range(0, 5));
      exe_branch_taken = 1'($urandom_range(0, 3) == 0);
      mem_req = 1'($urandom_range(0, 2) == 0);
      mem_ready = 1'($urandom_range(0, 3) != 0);
      if (i == 300) mem_ready = 0;
      cycle();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
